// File: rtl/noc_pkg.sv
// Shared NoC packet constants and the packetizer FSM state type.
package noc_pkg;

    localparam logic [3:0]  OP_WR_ACK     = 4'h1;
    localparam logic [3:0]  OP_RD_RSP     = 4'h2;
    localparam int          FLITS_PER_PKT = 6;
    localparam logic [15:0] TAIL_MARKER   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY,
        ST_TAIL
    } pkt_state_e;

endpackage

// File: rtl/noc_flit_checksum.sv
// Running 16-bit XOR over accepted flits; result visible the cycle after each accumulate.
// Clear has priority over accumulate, so a new packet can restart the sum on its capture cycle.
module noc_flit_checksum (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_accum,
    input  logic [15:0] i_flit,
    output logic [15:0] o_sum
);

    logic [15:0] sum_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sum_q <= '0;
        end else if (i_clear) begin
            sum_q <= '0;
        end else if (i_accum) begin
            sum_q <= sum_q ^ i_flit;
        end
    end

    assign o_sum = sum_q;

endmodule

// File: rtl/ram_to_noc_packetizer.sv
// RAM response -> 6-flit NoC packet (HEAD,B1..B4,TAIL); HEAD valid the cycle after capture, flits hold while i_flit_ready is low.
// Build option PKT_CHECKSUM_EN: TAIL carries the XOR of HEAD..B4 instead of the constant marker.
module ram_to_noc_packetizer
    import noc_pkg::*;
#(
    parameter int          ADDR_WIDTH = 14,
    parameter int          DATA_WIDTH = 32,
    parameter logic [5:0]  SRC_ID     = 6'd0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic                  i_read_write,
    input  logic [5:0]            i_dest,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_error,
    output logic                  o_ready,
    output logic [15:0]           o_flit,
    output logic                  o_flit_valid,
    input  logic                  i_flit_ready,
    output logic                  o_done
);

    localparam int         BODY_FLITS = FLITS_PER_PKT - 2;
    localparam logic [1:0] LAST_BODY  = 2'(BODY_FLITS - 1);

    pkt_state_e state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       done_q, done_d;

    logic                  rw_q;
    logic [5:0]            dest_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic        capture;
    logic [31:0] rdata32;
    logic [15:0] head_flit;
    logic [15:0] body_flit;
    logic [15:0] tail_flit;
    logic [15:0] flit;

    assign o_ready      = (state_q == ST_IDLE);
    assign o_flit_valid = (state_q != ST_IDLE);
    assign capture      = i_valid && o_ready;

    // Capture registers only load in IDLE, so fields stay frozen for the whole packet.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rw_q    <= 1'b0;
            dest_q  <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (capture) begin
            rw_q    <= i_read_write;
            dest_q  <= i_dest;
            addr_q  <= i_address;
            rdata_q <= i_rdata;
            err_q   <= i_error;
        end
    end

    assign rdata32   = 32'(rdata_q);
    assign head_flit = {(rw_q ? OP_RD_RSP : OP_WR_ACK), dest_q, SRC_ID};

    always_comb begin
        body_flit = '0;
        case (cnt_q)
            2'd0:    body_flit = 16'(addr_q);
            2'd1:    body_flit = rw_q ? rdata32[31:16] : 16'h0000;
            2'd2:    body_flit = rw_q ? rdata32[15:0]  : 16'h0000;
            default: body_flit = {15'd0, err_q};
        endcase
    end

`ifdef PKT_CHECKSUM_EN
    logic xfer;
    logic [15:0] csum;

    assign xfer = o_flit_valid && i_flit_ready;

    noc_flit_checksum u_csum (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (capture),
        .i_accum (xfer && (state_q != ST_TAIL)),
        .i_flit  (flit),
        .o_sum   (csum)
    );

    assign tail_flit = csum;
`else
    assign tail_flit = TAIL_MARKER;
`endif

    always_comb begin
        flit = '0;
        case (state_q)
            ST_HEAD: flit = head_flit;
            ST_BODY: flit = body_flit;
            ST_TAIL: flit = tail_flit;
            default: flit = '0;
        endcase
    end

    assign o_flit = flit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_HEAD;
                    cnt_d   = '0;
                end
            end
            ST_HEAD: begin
                if (i_flit_ready) state_d = ST_BODY;
            end
            ST_BODY: begin
                if (i_flit_ready) begin
                    if (cnt_q == LAST_BODY) begin
                        state_d = ST_TAIL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            ST_TAIL: begin
                if (i_flit_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign o_done = done_q;

endmodule

// File: tb/tb_ram_to_noc_packetizer.sv
// Scoreboard bench for ram_to_noc_packetizer: directed cases from the packet rules plus randomized traffic and backpressure.
module tb_ram_to_noc_packetizer;

    localparam int         AW  = 14;
    localparam int         DW  = 32;
    localparam logic [5:0] SRC = 6'd0;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          i_read_write;
    logic [5:0]    i_dest;
    logic [AW-1:0] i_address;
    logic [DW-1:0] i_rdata;
    logic          i_error;
    logic          o_ready;
    logic [15:0]   o_flit;
    logic          o_flit_valid;
    logic          i_flit_ready;
    logic          o_done;

    ram_to_noc_packetizer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRC_ID(SRC)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_read_write (i_read_write),
        .i_dest       (i_dest),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_error      (i_error),
        .o_ready      (o_ready),
        .o_flit       (o_flit),
        .o_flit_valid (o_flit_valid),
        .i_flit_ready (i_flit_ready),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;          // 0: always ready, 1: random, 2: driven by main sequence
    logic [15:0] exp_q[$];
    int          head_cyc_q[$];
    int  mon_idx = 0;
    bit  head_seen = 0;
    bit  done_pend = 0;
    int  last_done_cyc = -1;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(posedge i_clk) begin
        #1;
        if (rdy_mode == 0) i_flit_ready = 1'b1;
        else if (rdy_mode == 1) i_flit_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    // Reference packet: built arithmetically from the field definitions.
    function automatic void model_push(bit rd, logic [5:0] dest, logic [AW-1:0] addr,
                                       logic [31:0] data, bit err);
        logic [15:0] f[6];
        int op;
        op   = rd ? 2 : 1;
        f[0] = 16'(op * 4096 + int'(dest) * 64 + int'(SRC));
        f[1] = 16'(addr);
        f[2] = rd ? 16'(data / 65536) : 16'h0000;
        f[3] = rd ? 16'(data % 65536) : 16'h0000;
        f[4] = err ? 16'd1 : 16'd0;
`ifdef PKT_CHECKSUM_EN
        f[5] = 16'h0000;
        for (int i = 0; i < 5; i++) f[5] = f[5] ^ f[i];
`else
        f[5] = 16'hFFFF;
`endif
        for (int i = 0; i < 6; i++) exp_q.push_back(f[i]);
    endfunction

    // Monitor: compares every presented flit against the scoreboard head.
    always @(negedge i_clk) begin
        if (i_rst) begin
            chk("rst_flit_valid", {31'd0, o_flit_valid}, 32'd0);
            chk("rst_ready", {31'd0, o_ready}, 32'd1);
            chk("rst_done", {31'd0, o_done}, 32'd0);
            chk("rst_flit", {16'd0, o_flit}, 32'd0);
            exp_q.delete();
            head_cyc_q.delete();
            mon_idx   = 0;
            head_seen = 0;
            done_pend = 0;
        end else begin
            chk("done", {31'd0, o_done}, {31'd0, done_pend});
            if (o_done) last_done_cyc = cyc;
            done_pend = 0;
            chk("ready_vs_valid", {31'd0, o_ready}, {31'd0, !o_flit_valid});
            if (o_flit_valid) begin
                if (!head_seen && mon_idx == 0) begin
                    head_seen = 1;
                    if (head_cyc_q.size() == 0) chk("head_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                    else chk("head_latency", 32'(cyc), 32'(head_cyc_q.pop_front()));
                end
                if (exp_q.size() == 0) begin
                    chk("flit_unexpected", {16'd0, o_flit}, 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("flit%0d", mon_idx), {16'd0, o_flit}, {16'd0, exp_q[0]});
                    if (i_flit_ready) begin
                        void'(exp_q.pop_front());
                        mon_idx++;
                        if (mon_idx == 6) begin
                            mon_idx   = 0;
                            head_seen = 0;
                            done_pend = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input bit rd, input logic [5:0] dest, input logic [AW-1:0] addr,
                        input logic [31:0] data, input bit err, input bit keep, output int cap);
        @(posedge i_clk);
        #1;
        i_valid      = 1'b1;
        i_read_write = rd;
        i_dest       = dest;
        i_address    = addr;
        i_rdata      = data;
        i_error      = err;
        cap = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge i_clk);
            if (o_ready) begin
                cap = cyc;
                break;
            end
        end
        checks++;
        if (cap < 0) begin
            errors++;
            $display("FAIL capture_timeout: o_ready never high, expected capture");
        end else begin
            model_push(rd, dest, addr, data, err);
            head_cyc_q.push_back(cap + 1);
        end
        @(posedge i_clk);
        #1;
        if (!keep) i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge i_clk);
            if (exp_q.size() == 0 && !o_flit_valid) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: %0d flits pending, expected 0", exp_q.size());
        end
        repeat (2) @(negedge i_clk);
    endtask

    task automatic wait_flit(input int idx);
        bit ok;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge i_clk);
            #2;
            if (mon_idx == idx && o_flit_valid) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_flit%0d: flit not reached, expected valid", idx);
        end
    endtask

    initial begin
        int cap, cap2;
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_read_write = 1'b0;
        i_dest = '0;
        i_address = '0;
        i_rdata = '0;
        i_error = 1'b0;
        i_flit_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        // Write ack, dest 3, addr 0x10
        send(1'b0, 6'd3, 14'h0010, 32'h0, 1'b0, 1'b0, cap);
        wait_idle();
        chk("wr_done_cycle", 32'(last_done_cyc), 32'(cap + 7));

        // Read response, dest 5, addr 0x3FFF, data DEADBEEF
        send(1'b1, 6'd5, 14'h3FFF, 32'hDEADBEEF, 1'b0, 1'b0, cap);
        wait_idle();
        chk("rd_done_cycle", 32'(last_done_cyc), 32'(cap + 7));

        // Same read with 3 stall cycles on B2
        rdy_mode = 2;
        i_flit_ready = 1'b1;
        send(1'b1, 6'd5, 14'h3FFF, 32'hDEADBEEF, 1'b0, 1'b0, cap);
        wait_flit(2);
        i_flit_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_flit_ready = 1'b1;
        wait_idle();
        chk("stall_done_cycle", 32'(last_done_cyc), 32'(cap + 10));
        rdy_mode = 0;

        // Back-to-back: second request held valid throughout the first packet
        send(1'b1, 6'd7, 14'h0123, 32'h01234567, 1'b0, 1'b1, cap);
        send(1'b0, 6'd33, 14'h2AAA, 32'hFFFFFFFF, 1'b1, 1'b0, cap2);
        chk("b2b_capture_cycle", 32'(cap2), 32'(cap + 7));
        wait_idle();

        // Read with error set
        send(1'b1, 6'd5, 14'h3FFF, 32'hDEADBEEF, 1'b1, 1'b0, cap);
        wait_idle();

        // Reset while B3 is valid aborts the packet
        send(1'b1, 6'd12, 14'h0456, 32'hCAFEF00D, 1'b0, 1'b0, cap);
        wait_flit(3);
        i_rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, o_flit_valid}, 32'd0);
        chk("async_rst_ready", {31'd0, o_ready}, 32'd1);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        repeat (8) @(negedge i_clk);

        // Randomized traffic with random backpressure
        rdy_mode = 1;
        for (int n = 0; n < 30; n++) begin
            send(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 14'($urandom_range(0, 16383)),
                 $urandom(), 1'($urandom_range(0, 1)), (n != 29) && ($urandom_range(0, 1) == 1), cap);
        end
        wait_idle();
        rdy_mode = 0;
        repeat (2) @(negedge i_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_to_noc_packetizer.md
RAM_TO_NOC_PACKETIZER -- requirements
Module: ram_to_noc_packetizer

Interface
- REQ-001: Parameter ADDR_WIDTH, default 14, SHALL set the RAM address width carried in body flit 1.
- REQ-002: Parameter DATA_WIDTH, default 32, SHALL set the response data width carried in body flits 2-3.
- REQ-003: Parameter SRC_ID, default 6'd0, SHALL set the source node ID placed in the head flit.
- REQ-004: i_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
- REQ-005: i_rst  input  1  SHALL be an asynchronous, active-high reset.
- REQ-006: i_valid  input  1  SHALL indicate a response request is present.
- REQ-007: i_read_write  input  1  SHALL select the response type: 1 = read response, 0 = write ack.
- REQ-008: i_dest  input  6  SHALL give the destination node ID.
- REQ-009: i_address  input  ADDR_WIDTH  SHALL give the RAM address being answered.
- REQ-010: i_rdata  input  DATA_WIDTH  SHALL give the read data; it is ignored for write acks.
- REQ-011: i_error  input  1  SHALL be the RAM error status bit.
- REQ-012: o_ready  output  1  SHALL be high when a request can be captured.
- REQ-013: o_flit  output  16  SHALL carry the current flit.
- REQ-014: o_flit_valid  output  1  SHALL qualify o_flit.
- REQ-015: i_flit_ready  input  1  SHALL be downstream backpressure; a flit transfers when o_flit_valid and i_flit_ready are both high.
- REQ-016: o_done  output  1  SHALL pulse for one cycle per completed packet.

Function
- REQ-017: A packet SHALL be 6 flits in order: HEAD, B1, B2, B3, B4, TAIL.
- REQ-018: HEAD SHALL be {opcode[3:0], i_dest[5:0], SRC_ID[5:0]}, with opcode 4'h1 for a write ack and 4'h2 for a read response.
- REQ-019: B1 SHALL be the zero-extended address.
- REQ-020: B2 SHALL be rdata[31:16] and B3 SHALL be rdata[15:0]; for a write ack, B2 and B3 SHALL both be 16'h0000.
- REQ-021: B4 SHALL be {15'd0, i_error}.
- REQ-022: TAIL content SHALL be as defined under Configuration.
- REQ-023: The FSM SHALL have states IDLE, HEAD, BODY and TAIL; BODY SHALL use a 2-bit counter running 0-3 for B1-B4.
- REQ-024: In IDLE, o_ready SHALL be 1; in every other state, o_ready SHALL be 0.
- REQ-025: When i_valid and o_ready are both high, all inputs SHALL be registered and the FSM SHALL go IDLE->HEAD.
- REQ-026: o_flit_valid SHALL be 1 in HEAD, BODY and TAIL, and 0 in IDLE.
- REQ-027: The FSM SHALL advance one flit per transfer (HEAD->BODY, BODY count 3->TAIL, TAIL->IDLE).
- REQ-028: While o_flit_valid is high and i_flit_ready is low, o_flit and the state SHALL hold stable.
- REQ-029: Latency SHALL be: request captured in cycle N, HEAD valid in cycle N+1; with i_flit_ready held high, TAIL is valid in N+6 and o_done=1 with o_ready=1 in N+7.
- REQ-030: o_done SHALL be registered and high for the single cycle after the TAIL transfer.
- REQ-031: A request presented in that o_done cycle SHALL be captured, giving back-to-back packets with one idle cycle between them.
- REQ-032: i_valid SHALL be ignored while o_ready is 0; registered fields SHALL not change mid-packet.

Reset
- REQ-033: While i_rst=1, asynchronously: state=IDLE, counter=0, o_flit=16'h0000, o_flit_valid=0, o_done=0, o_ready=1, all capture registers=0.
- REQ-034: Reset asserted mid-packet SHALL abort the packet; no further flits of that packet are emitted after release.

Configuration
- REQ-035: Macro PKT_CHECKSUM_EN SHALL control the TAIL content.
- REQ-036: With PKT_CHECKSUM_EN defined, TAIL SHALL be the XOR of HEAD, B1, B2, B3 and B4.
- REQ-037: Without PKT_CHECKSUM_EN, TAIL SHALL be the constant 16'hFFFF and no checksum logic SHALL be present.

Structure
- REQ-038: Package noc_pkg SHALL hold the opcode constants (OP_WR_ACK=4'h1, OP_RD_RSP=4'h2), FLITS_PER_PKT=6, TAIL_MARKER=16'hFFFF and the FSM state typedef.
- REQ-039: Sub-module noc_flit_checksum (running 16-bit XOR with clear and accumulate enables) SHALL be instantiated only under PKT_CHECKSUM_EN.

Verification
- REQ-040: Write ack, dest=3, addr=0x0010, error=0, i_flit_ready=1 -> 0x10C0, 0x0010, 0x0000, 0x0000, 0x0000, then TAIL 0x10D0 (checksum) or 0xFFFF; o_done in N+7.
- REQ-041: Read response, dest=5, addr=0x3FFF, rdata=0xDEADBEEF -> 0x2140, 0x3FFF, 0xDEAD, 0xBEEF, 0x0000, then TAIL 0x7EFD (checksum) or 0xFFFF.
- REQ-042: Same read with i_flit_ready low for 3 cycles during B2 -> 0xDEAD held stable for all 3 cycles, no flit lost or duplicated, o_done delayed by 3 cycles.
- REQ-043: Second i_valid asserted throughout the first packet, and still asserted in the o_done cycle -> second request captured in the o_done cycle, its HEAD valid in the next cycle.
- REQ-044: i_rst pulsed while B3 is valid -> o_flit_valid=0 and o_ready=1 immediately; after release, nothing is emitted until a new request is captured.
- REQ-045: i_error=1 on a read -> B4=0x0001, and TAIL=0x7EFC with PKT_CHECKSUM_EN defined.
